// File: rtl/mini_alu_core_p.sv
// mini_alu_core_p: parametrised 2-stage fetch/execute core with a return stack and a generic I/O port.
// Define MINI_ALU_CORE_MUL_EN to execute opcode 15 as MUL; otherwise opcode 15 behaves as NOP.
module mini_alu_core_p #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned IP_W        = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned LED_W       = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [IP_W-1:0]       oIP,
  input  logic [4+3*ADDR_W-1:0] iInstruction,
  output logic [ADDR_W-1:0]     oRdAddr0,
  output logic [ADDR_W-1:0]     oRdAddr1,
  input  logic [DATA_W-1:0]     iRdData0,
  input  logic [DATA_W-1:0]     iRdData1,
  output logic                  oWrEn,
  output logic [ADDR_W-1:0]     oWrAddr,
  output logic [DATA_W-1:0]     oWrData,
  output logic                  oIoWrite,
  output logic [ADDR_W-1:0]     oIoAddr,
  output logic [DATA_W-1:0]     oIoData,
  input  logic [DATA_W-1:0]     iIoData,
  output logic [LED_W-1:0]      oLed,
  output logic                  oStackErr
);

  localparam int unsigned SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned INS_W = 4 + 3*ADDR_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_STO  = 4'd3,
    OP_BLE  = 4'd4,
    OP_JMP  = 4'd5,
    OP_CALL = 4'd6,
    OP_RET  = 4'd7,
    OP_LED  = 4'd8,
    OP_OUT  = 4'd9,
    OP_IN   = 4'd10,
    OP_AND  = 4'd11,
    OP_OR   = 4'd12,
    OP_XOR  = 4'd13,
    OP_SHL  = 4'd14,
    OP_MUL  = 4'd15
  } opcode_e;

  opcode_e           exOp;
  logic [ADDR_W-1:0] exDst;
  logic [ADDR_W-1:0] exSrc1;
  logic [ADDR_W-1:0] exSrc0;
  logic [IP_W-1:0]   ipReg;

  logic [IP_W-1:0]   stackMem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              stackFull;
  logic              stackEmpty;
  logic [IDX_W-1:0]  pushIdx;
  logic [IDX_W-1:0]  topIdx;

  logic              fwdValid;
  logic [ADDR_W-1:0] fwdAddr;
  logic [DATA_W-1:0] fwdData;

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] imm;
  logic [IP_W-1:0]   target;
  logic [DATA_W-1:0] res;
  logic              wrReq;
  logic              ioReq;
  logic              redirect;
  logic [IP_W-1:0]   redirTarget;

  assign oRdAddr0 = iInstruction[ADDR_W-1:0];
  assign oRdAddr1 = iInstruction[2*ADDR_W-1:ADDR_W];

  // The RAM returns stale data when last cycle's write hits the address being read.
  assign opA = (fwdValid && fwdAddr == exSrc1) ? fwdData : iRdData1;
  assign opB = (fwdValid && fwdAddr == exSrc0) ? fwdData : iRdData0;

  assign imm    = DATA_W'({exSrc1, exSrc0});
  assign target = IP_W'(exDst);

  assign stackFull  = (sp == SP_W'(STACK_DEPTH));
  assign stackEmpty = (sp == '0);
  assign pushIdx    = IDX_W'(sp);
  assign topIdx     = IDX_W'(sp - SP_W'(1));

  always_comb begin
    res         = '0;
    wrReq       = 1'b0;
    ioReq       = 1'b0;
    redirect    = 1'b0;
    redirTarget = target;
    case (exOp)
      OP_ADD: begin res = opA + opB; wrReq = 1'b1; end
      OP_SUB: begin res = opA - opB; wrReq = 1'b1; end
      OP_STO: begin res = imm;       wrReq = 1'b1; end
      OP_BLE: redirect = (opA <= opB);
      OP_JMP: redirect = 1'b1;
      OP_CALL: redirect = 1'b1;
      OP_RET: begin
        redirect    = 1'b1;
        redirTarget = stackEmpty ? '0 : stackMem[topIdx];
      end
      OP_OUT: ioReq = 1'b1;
      OP_IN:  begin res = iIoData;     wrReq = 1'b1; end
      OP_AND: begin res = opA & opB;   wrReq = 1'b1; end
      OP_OR:  begin res = opA | opB;   wrReq = 1'b1; end
      OP_XOR: begin res = opA ^ opB;   wrReq = 1'b1; end
      OP_SHL: begin res = opA << opB[SH_W-1:0]; wrReq = 1'b1; end
`ifdef MINI_ALU_CORE_MUL_EN
      OP_MUL: begin res = opA * opB;   wrReq = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign oIP      = Reset ? '0 : (redirect ? redirTarget : ipReg);
  assign oWrEn    = wrReq & ~Reset;
  assign oWrAddr  = exDst;
  assign oWrData  = res;
  assign oIoWrite = ioReq & ~Reset;
  assign oIoAddr  = exDst;
  assign oIoData  = opA;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ipReg     <= '0;
      exOp      <= OP_NOP;
      exDst     <= '0;
      exSrc1    <= '0;
      exSrc0    <= '0;
      sp        <= '0;
      oLed      <= '0;
      oStackErr <= 1'b0;
      fwdValid  <= 1'b0;
      fwdAddr   <= '0;
      fwdData   <= '0;
    end else begin
      ipReg    <= oIP + IP_W'(1);
      exOp     <= opcode_e'(iInstruction[INS_W-1 -: 4]);
      exDst    <= iInstruction[3*ADDR_W-1:2*ADDR_W];
      exSrc1   <= iInstruction[2*ADDR_W-1:ADDR_W];
      exSrc0   <= iInstruction[ADDR_W-1:0];
      fwdValid <= oWrEn;
      fwdAddr  <= oWrAddr;
      fwdData  <= oWrData;
      if (exOp == OP_LED) oLed <= LED_W'(opA);
      if (exOp == OP_CALL) begin
        if (stackFull) oStackErr <= 1'b1;
        else           sp <= sp + SP_W'(1);
      end
      if (exOp == OP_RET) begin
        if (stackEmpty) oStackErr <= 1'b1;
        else            sp <= sp - SP_W'(1);
      end
    end
  end

  // Stack storage needs no reset: the pointer alone defines what is valid.
  always_ff @(posedge Clock) begin
    if (!Reset && exOp == OP_CALL && !stackFull) stackMem[pushIdx] <= ipReg;
  end

endmodule

// File: tb/tb_mini_alu_core_p.sv
// tb_mini_alu_core_p: vector table, hand sequences and a random program checked against an ISA-level model.
module tb_mini_alu_core_p;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned SD = 2;
  localparam int unsigned LW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [IW-1:0] oIP;
  logic [27:0]   iInstruction;
  logic [AW-1:0] oRdAddr0, oRdAddr1;
  logic [DW-1:0] iRdData0, iRdData1;
  logic          oWrEn;
  logic [AW-1:0] oWrAddr;
  logic [DW-1:0] oWrData;
  logic          oIoWrite;
  logic [AW-1:0] oIoAddr;
  logic [DW-1:0] oIoData;
  logic [DW-1:0] iIoData = 16'h1234;
  logic [LW-1:0] oLed;
  logic          oStackErr;

  mini_alu_core_p #(.DATA_W(DW), .ADDR_W(AW), .IP_W(IW), .STACK_DEPTH(SD), .LED_W(LW)) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oRdAddr0(oRdAddr0), .oRdAddr1(oRdAddr1), .iRdData0(iRdData0), .iRdData1(iRdData1),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oIoWrite(oIoWrite), .oIoAddr(oIoAddr), .oIoData(oIoData), .iIoData(iIoData),
    .oLed(oLed), .oStackErr(oStackErr)
  );

  always #5 Clock = ~Clock;

  logic [27:0] rom [256];
  logic [15:0] ram [256];
  logic [15:0] ramInitVal [256];
  logic        ramLoad = 1'b0;

  assign iInstruction = rom[oIP[7:0]];

  // Synchronous-read RAM: a same-edge write is not visible to the read.
  always @(posedge Clock) begin
    iRdData0 <= ram[oRdAddr0];
    iRdData1 <= ram[oRdAddr1];
    if (ramLoad) begin
      for (int i = 0; i < 256; i++) ram[i] <= ramInitVal[i];
    end else if (oWrEn) begin
      ram[oWrAddr] <= oWrData;
    end
  end

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
  endtask

  // Leaves the bench just after a falling edge with Reset low: the first post-reset cycle.
  task automatic doReset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  dst;
    logic        expWr;
    logic [15:0] expData;
    logic        expIo;
    logic [15:0] expIp;
    logic [7:0]  expLed;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input string n, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [7:0] d, input logic ew,
                                 input logic [15:0] ed, input logic eio, input logic [15:0] eip,
                                 input logic [7:0] el);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.dst = d;
    v.expWr = ew; v.expData = ed; v.expIo = eio; v.expIp = eip; v.expLed = el;
    vecs.push_back(v);
  endfunction

  // ISA-level reference state for the random program.
  logic [15:0] mdl [256];
  logic [15:0] stk [$];

  task automatic runRandom(input int cycles);
    logic [27:0] ins;
    logic [3:0]  op;
    logic [7:0]  d, s1, s0;
    logic [15:0] a, b, w, seq, nxt, curPc;
    logic        wr, io, mErr, nErr;
    logic [7:0]  mLed, nLed;

    clearRom();
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 15));
      d  = (op == 4'd4 || op == 4'd5 || op == 4'd6) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 7));
      rom[i] = enc(op, d, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
      ramInitVal[i] = 16'($urandom);
      mdl[i] = ramInitVal[i];
    end
    ramLoad = 1'b1;
    doReset();
    ramLoad = 1'b0;
    #1;
    check("rnd.ip0", 32'(oIP), 32'h0);
    curPc = 16'h0; mLed = 8'h0; mErr = 1'b0;
    stk.delete();
    for (int k = 1; k <= cycles; k++) begin
      @(negedge Clock);
      iIoData = 16'($urandom);
      #1;
      ins = rom[curPc[7:0]];
      {op, d, s1, s0} = ins;
      a = mdl[s1]; b = mdl[s0];
      seq = curPc + 16'd1; nxt = seq;
      wr = 1'b0; io = 1'b0; w = 16'h0; nLed = mLed; nErr = mErr;
      case (op)
        4'd1: begin wr = 1'b1; w = a + b; end
        4'd2: begin wr = 1'b1; w = a - b; end
        4'd3: begin wr = 1'b1; w = {s1, s0}; end
        4'd4: if (a <= b) nxt = {8'h0, d};
        4'd5: nxt = {8'h0, d};
        4'd6: begin
          if (stk.size() < SD) stk.push_back(seq);
          else nErr = 1'b1;
          nxt = {8'h0, d};
        end
        4'd7: begin
          if (stk.size() == 0) begin nxt = 16'h0; nErr = 1'b1; end
          else nxt = stk.pop_back();
        end
        4'd8: nLed = a[7:0];
        4'd9: io = 1'b1;
        4'd10: begin wr = 1'b1; w = iIoData; end
        4'd11: begin wr = 1'b1; w = a & b; end
        4'd12: begin wr = 1'b1; w = a | b; end
        4'd13: begin wr = 1'b1; w = a ^ b; end
        4'd14: begin wr = 1'b1; w = a << b[3:0]; end
`ifdef MINI_ALU_CORE_MUL_EN
        4'd15: begin wr = 1'b1; w = a * b; end
`endif
        default: ;
      endcase
      check("rnd.ip", 32'(oIP), 32'(nxt));
      check("rnd.wrEn", 32'(oWrEn), 32'(wr));
      if (wr) begin
        check("rnd.wrAddr", 32'(oWrAddr), 32'(d));
        check("rnd.wrData", 32'(oWrData), 32'(w));
      end
      check("rnd.ioWrite", 32'(oIoWrite), 32'(io));
      if (io) begin
        check("rnd.ioAddr", 32'(oIoAddr), 32'(d));
        check("rnd.ioData", 32'(oIoData), 32'(a));
      end
      check("rnd.led", 32'(oLed), 32'(mLed));
      check("rnd.stackErr", 32'(oStackErr), 32'(mErr));
      if (wr) mdl[d] = w;
      mLed = nLed; mErr = nErr; curPc = nxt;
    end
  endtask

  initial begin
    vec_t v;
    logic [15:0] ipSeq [6];

    // Reset held for three cycles, then the IP counts from 0.
    clearRom();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); #1;
      check("rst.ipHeld", 32'(oIP), 32'h0);
      check("rst.wrEnHeld", 32'(oWrEn), 32'h0);
    end
    Reset = 1'b0;
    #1;
    check("rst.led", 32'(oLed), 32'h0);
    check("rst.stackErr", 32'(oStackErr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("rst.ipRun", 32'(oIP), 32'(i));
      check("rst.wrEnRun", 32'(oWrEn), 32'h0);
      @(negedge Clock); #1;
    end

    addVec("add", 4'd1, 16'd5, 16'd3, 8'd3, 1'b1, 16'd8, 1'b0, 16'd3, 8'h0);
    addVec("sub", 4'd2, 16'd3, 16'd5, 8'd3, 1'b1, 16'hFFFE, 1'b0, 16'd3, 8'h0);
    addVec("sto", 4'd3, 16'd0, 16'd0, 8'd9, 1'b1, 16'h0102, 1'b0, 16'd3, 8'h0);
    addVec("bleTaken", 4'd4, 16'd3, 16'd5, 8'h20, 1'b0, 16'h0, 1'b0, 16'h20, 8'h0);
    addVec("bleNot", 4'd4, 16'd6, 16'd5, 8'h20, 1'b0, 16'h0, 1'b0, 16'd3, 8'h0);
    addVec("bleEq", 4'd4, 16'd5, 16'd5, 8'h20, 1'b0, 16'h0, 1'b0, 16'h20, 8'h0);
    addVec("bleUns", 4'd4, 16'hFFFF, 16'd1, 8'h20, 1'b0, 16'h0, 1'b0, 16'd3, 8'h0);
    addVec("jmp", 4'd5, 16'd0, 16'd0, 8'h40, 1'b0, 16'h0, 1'b0, 16'h40, 8'h0);
    addVec("led", 4'd8, 16'h01A5, 16'd0, 8'd0, 1'b0, 16'h0, 1'b0, 16'd3, 8'hA5);
    addVec("out", 4'd9, 16'h02A5, 16'd0, 8'h07, 1'b0, 16'h0, 1'b1, 16'd3, 8'h0);
    addVec("in", 4'd10, 16'd0, 16'd0, 8'h04, 1'b1, 16'h1234, 1'b0, 16'd3, 8'h0);
    addVec("and", 4'd11, 16'hF0F0, 16'h3CC3, 8'd5, 1'b1, 16'h30C0, 1'b0, 16'd3, 8'h0);
    addVec("or", 4'd12, 16'hF0F0, 16'h3CC3, 8'd5, 1'b1, 16'hFCF3, 1'b0, 16'd3, 8'h0);
    addVec("xor", 4'd13, 16'hF0F0, 16'h3CC3, 8'd5, 1'b1, 16'hCC33, 1'b0, 16'd3, 8'h0);
    addVec("shl3", 4'd14, 16'h0003, 16'h0013, 8'd6, 1'b1, 16'h0018, 1'b0, 16'd3, 8'h0);
    addVec("shl0", 4'd14, 16'h8001, 16'h0010, 8'd6, 1'b1, 16'h8001, 1'b0, 16'd3, 8'h0);
    addVec("shl15", 4'd14, 16'h0003, 16'h000F, 8'd6, 1'b1, 16'h8000, 1'b0, 16'd3, 8'h0);
`ifdef MINI_ALU_CORE_MUL_EN
    addVec("mul", 4'd15, 16'd300, 16'd300, 8'd7, 1'b1, 16'h5F90, 1'b0, 16'd3, 8'h0);
`else
    addVec("mul", 4'd15, 16'd300, 16'd300, 8'd7, 1'b0, 16'h0, 1'b0, 16'd3, 8'h0);
`endif
    addVec("nop", 4'd0, 16'd7, 16'd9, 8'd3, 1'b0, 16'h0, 1'b0, 16'd3, 8'h0);

    // STO r1,a ; STO r2,b ; op dst,r1,r2 back to back, so r2 must be forwarded.
    iIoData = 16'h1234;
    foreach (vecs[i]) begin
      v = vecs[i];
      clearRom();
      rom[0] = enc(4'd3, 8'd1, v.a[15:8], v.a[7:0]);
      rom[1] = enc(4'd3, 8'd2, v.b[15:8], v.b[7:0]);
      rom[2] = enc(v.op, v.dst, 8'd1, 8'd2);
      doReset();
      repeat (3) @(negedge Clock);
      #1;
      check({v.name, ".wrEn"}, 32'(oWrEn), 32'(v.expWr));
      if (v.expWr) begin
        check({v.name, ".wrAddr"}, 32'(oWrAddr), 32'(v.dst));
        check({v.name, ".wrData"}, 32'(oWrData), 32'(v.expData));
      end
      check({v.name, ".ioWrite"}, 32'(oIoWrite), 32'(v.expIo));
      if (v.expIo) begin
        check({v.name, ".ioAddr"}, 32'(oIoAddr), 32'(v.dst));
        check({v.name, ".ioData"}, 32'(oIoData), 32'(v.a));
      end
      check({v.name, ".ip"}, 32'(oIP), 32'(v.expIp));
      @(negedge Clock); #1;
      check({v.name, ".led"}, 32'(oLed), 32'(v.expLed));
    end

    // Three nested CALLs on a 2-deep stack, then three RETs.
    clearRom();
    rom[8'h00] = enc(4'd6, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = enc(4'd6, 8'h20, 8'd0, 8'd0);
    rom[8'h20] = enc(4'd6, 8'h30, 8'd0, 8'd0);
    rom[8'h30] = enc(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h11] = enc(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h01] = enc(4'd7, 8'h00, 8'd0, 8'd0);
    ipSeq[0] = 16'h10; ipSeq[1] = 16'h20; ipSeq[2] = 16'h30;
    ipSeq[3] = 16'h11; ipSeq[4] = 16'h01; ipSeq[5] = 16'h00;
    doReset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clock); #1;
      check("stk.ip", 32'(oIP), 32'(ipSeq[c-1]));
      check("stk.err", 32'(oStackErr), (c >= 4) ? 32'h1 : 32'h0);
    end
    @(negedge Clock); #1;
    check("stk.errSticky", 32'(oStackErr), 32'h1);
    check("stk.reCall", 32'(oIP), 32'h10);

    // Reset with a live stack entry: the entry must be gone afterwards.
    rom[8'h00] = enc(4'd7, 8'h00, 8'd0, 8'd0);
    doReset();
    #1;
    check("stkRst.err", 32'(oStackErr), 32'h0);
    @(negedge Clock); #1;
    check("stkRst.retIp", 32'(oIP), 32'h0);
    @(negedge Clock); #1;
    check("stkRst.errSet", 32'(oStackErr), 32'h1);

    runRandom(300);
    runRandom(300);
    runRandom(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
